// File: rtl/ram_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ram_wb_arbiter
// Description : Two-master Wishbone arbiter in front of a single-port RAM
//               slave. m0 is the instruction-fetch master and m1 the data
//               master. The bus is granted for a whole Wishbone cycle
//               (classic or incrementing burst). Simultaneous requests are
//               resolved round-robin. A wait-state watchdog answers a hung
//               access with a one-cycle err pulse.
// Ports       : clk_i, rst_i (async, active-high)
//               mN_*_i  : master N request (dat, adr, we, cyc, stb, sel, cti)
//               mN_*_o  : master N response (dat, ack, err)
//               s_*_o   : slave-side request
//               s_dat_i, s_ack_i : slave response
// Revision    : 1.0 - initial release
// ============================================================================
module ram_wb_arbiter #(
    parameter int ADR_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic [31:0]            m0_dat_i,
    input  logic [ADR_WIDTH-1:2]   m0_adr_i,
    input  logic                   m0_we_i,
    input  logic                   m0_cyc_i,
    input  logic                   m0_stb_i,
    input  logic [3:0]             m0_sel_i,
    input  logic [2:0]             m0_cti_i,
    output logic [31:0]            m0_dat_o,
    output logic                   m0_ack_o,
    output logic                   m0_err_o,

    input  logic [31:0]            m1_dat_i,
    input  logic [ADR_WIDTH-1:2]   m1_adr_i,
    input  logic                   m1_we_i,
    input  logic                   m1_cyc_i,
    input  logic                   m1_stb_i,
    input  logic [3:0]             m1_sel_i,
    input  logic [2:0]             m1_cti_i,
    output logic [31:0]            m1_dat_o,
    output logic                   m1_ack_o,
    output logic                   m1_err_o,

    output logic [31:0]            s_dat_o,
    output logic [ADR_WIDTH-1:2]   s_adr_o,
    output logic                   s_we_o,
    output logic [3:0]             s_sel_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    output logic [2:0]             s_cti_o,
    input  logic [31:0]            s_dat_i,
    input  logic                   s_ack_i
);

    localparam logic [2:0] c_CTI_EOB = 3'b111;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last;     // last granted master, decides ties
    logic [7:0] r_cnt;      // consecutive unacknowledged strobe cycles

    logic w_gnt0;
    logic w_gnt1;
    logic w_cur_cyc;
    logic w_timeout;

    assign w_gnt0    = (r_state == GNT0);
    assign w_gnt1    = (r_state == GNT1);
    assign w_cur_cyc = w_gnt1 ? m1_cyc_i : m0_cyc_i;

    // ------------------------------------------------------------------------
    // Slave request mux. Outside a grant the bus is parked with cti = 111 so
    // that a RAM still bursting for an aborted master stops acknowledging.
    // ------------------------------------------------------------------------
    always_comb begin
        s_dat_o = '0;
        s_adr_o = '0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = c_CTI_EOB;
        if (w_gnt0) begin
            s_dat_o = m0_dat_i;
            s_adr_o = m0_adr_i;
            s_we_o  = m0_cyc_i & m0_we_i;
            s_sel_o = m0_sel_i;
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_cyc_i & m0_stb_i;
            s_cti_o = m0_cti_i;
        end else if (w_gnt1) begin
            s_dat_o = m1_dat_i;
            s_adr_o = m1_adr_i;
            s_we_o  = m1_cyc_i & m1_we_i;
            s_sel_o = m1_sel_i;
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_cyc_i & m1_stb_i;
            s_cti_o = m1_cti_i;
        end
    end

    // s_stb_o is already zero outside a grant, so no state term is needed.
    assign w_timeout = s_stb_o & (r_cnt == c_TIMEOUT);

    // Read data is broadcast; only ack/err qualify which master owns it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = w_gnt0 & s_ack_i;
    assign m1_ack_o = w_gnt1 & s_ack_i;
    assign m0_err_o = w_gnt0 & w_timeout;
    assign m1_err_o = w_gnt1 & w_timeout;

    // ------------------------------------------------------------------------
    // Grant FSM and watchdog. A grant always returns through IDLE, which
    // gives the other master a slot and parks the slave between cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;    // m0 wins the first tie
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                        r_state <= GNT0;
                        r_last  <= 1'b0;
                    end else if (m1_cyc_i) begin
                        r_state <= GNT1;
                        r_last  <= 1'b1;
                    end
                end
                GNT0, GNT1: begin
                    if (!w_cur_cyc) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (w_timeout || !s_stb_o || s_ack_i) begin
                        // Restart the count after an err so it repeats
                        // every TIMEOUT+1 strobe cycles while the grant holds.
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
